// File: rtl/seg_serial_rx.sv
`timescale 1ns/1ps
// seg_serial_rx
// Receiving end of the serial 7-segment display link. The link inputs are
// oversampled in the clk_100mhz domain, and each frame is deserialised into a
// parallel segment word.
//
// Ports
//   clk_100mhz   in   system clock, rising edge
//   RSTN         in   async active-low reset
//   seg_clk      in   link shift clock; data is sampled on its rising edge
//   seg_sout     in   link serial data, MSB first
//   SEG_PEN      in   link parallel-enable; its rising edge ends the frame
//   seg_clm      in   link clear, active-low, level-sensitive
//   par_data     out  last good frame; the MSB is the first bit shifted in
//   frame_valid  out  1-cycle pulse: par_data was just loaded with a good frame
//   frame_err    out  1-cycle pulse: frame ended with a bit count != DATA_BITS
//   bit_cnt      out  bits received so far in the current frame (saturating)
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_EMPTY   | no bits received in the current frame
// ST_SHIFTING| 0 < bit_cnt < DATA_BITS
// ST_FULL    | exactly DATA_BITS bits received, so the frame can be latched
// ST_OVER    | more than DATA_BITS bits received; frame will be rejected
module seg_serial_rx #(
  parameter int DATA_BITS   = 64,
  parameter int SYNC_STAGES = 2,
  localparam int CNT_W      = $clog2(DATA_BITS + 1)
) (
  input  logic                 clk_100mhz,
  input  logic                 RSTN,
  input  logic                 seg_clk,
  input  logic                 seg_sout,
  input  logic                 SEG_PEN,
  input  logic                 seg_clm,
  output logic [DATA_BITS-1:0] par_data,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     bit_cnt
);

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_SHIFTING = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;
  localparam logic [1:0] ST_OVER     = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_BITS);

  // All four link inputs use the same synchroniser depth, so data stays
  // aligned with the shift clock that qualifies it.
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] sout_sync_q;
  logic [SYNC_STAGES-1:0] pen_sync_q;
  logic [SYNC_STAGES-1:0] clm_sync_q;
  logic                   clk_prev_q;
  logic                   pen_prev_q;

  logic clk_s, sout_s, pen_s, clm_s;
  logic clk_rise, pen_rise, clr;

  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] par_q, par_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           state_q, state_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      clk_sync_q  <= '0;
      sout_sync_q <= '0;
      pen_sync_q  <= '0;
      clm_sync_q  <= '0;
      clk_prev_q  <= 1'b0;
      pen_prev_q  <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], seg_clk};
      sout_sync_q <= {sout_sync_q[SYNC_STAGES-2:0], seg_sout};
      pen_sync_q  <= {pen_sync_q[SYNC_STAGES-2:0], SEG_PEN};
      clm_sync_q  <= {clm_sync_q[SYNC_STAGES-2:0], seg_clm};
      clk_prev_q  <= clk_s;
      pen_prev_q  <= pen_s;
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign sout_s = sout_sync_q[SYNC_STAGES-1];
  assign pen_s  = pen_sync_q[SYNC_STAGES-1];
  assign clm_s  = clm_sync_q[SYNC_STAGES-1];

  assign clk_rise = clk_s & ~clk_prev_q;
  assign pen_rise = pen_s & ~pen_prev_q;
  // The synced clear flops come out of reset at 0. Because of that, the
  // receiver stays in clear for a few cycles after RSTN is released.
  assign clr      = ~clm_s;

  always_comb begin
    shift_d = shift_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
      state_d = ST_EMPTY;
    end else begin
      if (clk_rise) begin
        // The shift keeps running past a full frame, so the newest DATA_BITS
        // bits are always held; the overflow state rejects the frame later.
        shift_d = DATA_BITS'({shift_q, sout_s});
        case (state_q)
          ST_FULL, ST_OVER: state_d = ST_OVER;
          default: begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_d == CNT_MAX) ? ST_FULL : ST_SHIFTING;
          end
        endcase
      end
      // The frame end looks at the post-shift view. Because of that, a bit
      // shifted in on the same cycle is part of the frame.
      if (pen_rise) begin
        if (state_d == ST_FULL) begin
          par_d   = shift_d;
          valid_d = 1'b1;
        end else begin
          err_d   = 1'b1;
        end
        cnt_d   = '0;
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      shift_q <= '0;
      par_q   <= '0;
      cnt_q   <= '0;
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign par_data    = par_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign bit_cnt     = cnt_q;

endmodule

// File: tb/tb_seg_serial_rx.sv
`timescale 1ns/1ps
module tb_seg_serial_rx;

  localparam int N = 64;

  logic          clk_100mhz = 1'b0;
  logic          RSTN;
  logic          seg_clk;
  logic          seg_sout;
  logic          SEG_PEN;
  logic          seg_clm;
  logic [N-1:0]  par_data;
  logic          frame_valid;
  logic          frame_err;
  logic [6:0]    bit_cnt;

  seg_serial_rx #(.DATA_BITS(N), .SYNC_STAGES(2)) dut (
    .clk_100mhz (clk_100mhz),
    .RSTN       (RSTN),
    .seg_clk    (seg_clk),
    .seg_sout   (seg_sout),
    .SEG_PEN    (SEG_PEN),
    .seg_clm    (seg_clm),
    .par_data   (par_data),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the bits received since the last frame end, clear or reset.
  bit           rx_q[$];
  logic [N-1:0] exp_par;

  int n_fv = 0, n_fe = 0, n_both = 0, n_consec = 0;
  logic prev_pulse = 1'b0;

  always @(negedge clk_100mhz) begin
    if (frame_valid) n_fv++;
    if (frame_err) n_fe++;
    if (frame_valid && frame_err) n_both++;
    if ((frame_valid || frame_err) && prev_pulse) n_consec++;
    prev_pulse = frame_valid | frame_err;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int exp_cnt();
    return (rx_q.size() > N) ? N : rx_q.size();
  endfunction

  task automatic send_bit(input logic b);
    seg_sout = b;
    repeat (6) @(negedge clk_100mhz);
    seg_clk = 1'b1;
    rx_q.push_back(b);
    repeat (6) @(negedge clk_100mhz);
    seg_clk = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  // SEG_PEN is assumed to be already high. This task settles the frame
  // against the model and then returns the link to idle.
  task automatic finish_frame(input string tag, input int fv0, input int fe0);
    bit good;
    logic [N-1:0] packed_v;
    good = (rx_q.size() == N);
    packed_v = '0;
    foreach (rx_q[i]) packed_v = {packed_v[N-2:0], logic'(rx_q[i])};
    if (good) exp_par = packed_v;
    rx_q.delete();
    repeat (10) @(negedge clk_100mhz);
    SEG_PEN = 1'b0;
    seg_clk = 1'b0;
    repeat (6) @(negedge clk_100mhz);
    check_eq({tag, ".valid"}, 64'(n_fv - fv0), good ? 64'd1 : 64'd0);
    check_eq({tag, ".err"},   64'(n_fe - fe0), good ? 64'd0 : 64'd1);
    check_eq({tag, ".par"},   par_data, exp_par);
    check_eq({tag, ".cnt"},   64'(bit_cnt), 64'd0);
  endtask

  task automatic end_frame(input string tag);
    int fv0, fe0;
    fv0 = n_fv; fe0 = n_fe;
    SEG_PEN = 1'b1;
    finish_frame(tag, fv0, fe0);
  endtask

  task automatic clear_link();
    seg_clm = 1'b0;
    repeat (5) @(negedge clk_100mhz);
    rx_q.delete();
    check_eq("clr.cnt", 64'(bit_cnt), 64'd0);
    repeat (5) @(negedge clk_100mhz);
    seg_clm = 1'b1;
    repeat (6) @(negedge clk_100mhz);
  endtask

  initial begin
    int fv0, fe0, len, sel;
    logic [63:0] w;
    RSTN = 1'b0; seg_clk = 1'b0; seg_sout = 1'b0; SEG_PEN = 1'b0; seg_clm = 1'b1;
    exp_par = '0;
    repeat (3) @(negedge clk_100mhz);
    check_eq("rst.par", par_data, 64'd0);
    check_eq("rst.cnt", 64'(bit_cnt), 64'd0);
    check_eq("rst.pulse", {62'd0, frame_valid, frame_err}, 64'd0);
    RSTN = 1'b1;
    repeat (6) @(negedge clk_100mhz);

    // Good frame
    send_word(64'h0123_4567_89AB_CDEF, 64);
    check_eq("t2.cnt_full", 64'(bit_cnt), 64'(exp_cnt()));
    end_frame("t2");

    // Short frame
    send_word(64'h0123_4567_89AB_CDEF, 63);
    check_eq("t3.cnt", 64'(bit_cnt), 64'(exp_cnt()));
    end_frame("t3");

    // Long frame, followed by a good frame
    send_bit(1'b1);
    send_word(64'hFFFF_0000_FFFF_0000, 64);
    check_eq("t4.cnt_sat", 64'(bit_cnt), 64'(exp_cnt()));
    end_frame("t4.long");
    send_word(64'h1, 64);
    end_frame("t4.good");

    // Clear mid-frame, then a good frame
    send_word(64'h3FFF_FFFF, 30);
    check_eq("t5.cnt30", 64'(bit_cnt), 64'(exp_cnt()));
    clear_link();
    send_word(64'hA5A5_A5A5_A5A5_A5A5, 64);
    end_frame("t5");

    // A frame-end pulse while clear is held must be ignored
    fv0 = n_fv; fe0 = n_fe;
    seg_clm = 1'b0;
    repeat (4) @(negedge clk_100mhz);
    SEG_PEN = 1'b1;
    repeat (6) @(negedge clk_100mhz);
    SEG_PEN = 1'b0;
    repeat (6) @(negedge clk_100mhz);
    seg_clm = 1'b1;
    repeat (6) @(negedge clk_100mhz);
    check_eq("t5.pen_in_clr", 64'((n_fv - fv0) + (n_fe - fe0)), 64'd0);
    check_eq("t5.par_kept", par_data, exp_par);

    // Last shift-clock rise coincides with SEG_PEN rise
    w = 64'hC3C3_1234_5678_9ABD;
    send_word(w >> 1, 63);
    seg_sout = w[0];
    repeat (6) @(negedge clk_100mhz);
    fv0 = n_fv; fe0 = n_fe;
    seg_clk = 1'b1;
    SEG_PEN = 1'b1;
    rx_q.push_back(w[0]);
    finish_frame("t6", fv0, fe0);

    // Randomized frames, some cleared part-way
    for (int it = 0; it < 14; it++) begin
      w = {$urandom, $urandom};
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1, 2: len = N;
        3: len = N - 1;
        4: len = N + 1;
        default: len = $urandom_range(0, 70);
      endcase
      if ($urandom_range(0, 4) == 0) begin
        send_word(w, 10);
        clear_link();
      end
      for (int b = 0; b < len; b++) send_bit(w[(len - 1 - b) % 64]);
      check_eq("rnd.cnt", 64'(bit_cnt), 64'(exp_cnt()));
      end_frame("rnd");
    end

    // Reset mid-shift
    send_word(64'hFFFF_FFFF, 20);
    RSTN = 1'b0;
    #1;
    check_eq("t1.par", par_data, 64'd0);
    check_eq("t1.cnt", 64'(bit_cnt), 64'd0);
    check_eq("t1.pulse", {62'd0, frame_valid, frame_err}, 64'd0);
    rx_q.delete();
    exp_par = '0;
    repeat (3) @(negedge clk_100mhz);
    RSTN = 1'b1;
    repeat (6) @(negedge clk_100mhz);
    send_word(64'hDEAD_BEEF_0BAD_F00D, 64);
    end_frame("t1.after");

    check_eq("pulse_overlap", 64'(n_both), 64'd0);
    check_eq("pulse_consec", 64'(n_consec), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got no end, expected finish");
    $fatal(1);
  end

endmodule
